uart_pack_fifo_top: RTL and testbench

- Single-clock receive datapath: a UART 8N1 receiver feeds a byte FIFO.
- A packer drains the byte FIFO, assembles 16 bytes into one 128-bit word and pushes the word into a word FIFO.
- Downstream logic (AXI/DDR writer) pops words with r_en.

---
 rtl/uart_pack_fifo_top.sv | 205 ++++++++++++++++++++
 tb/tb_uart_pack_fifo_top.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_pack_fifo_top.sv
// uart_pack_fifo_top
//   Single-clock receive datapath. It has three parts:
//   - UART 8N1 receiver: a two-flop synchronizer and a 4-state FSM.
//   - Byte FIFO: DEPTH entries, asynchronous read of the head entry.
//   - Packer and word FIFO: the packer gathers WORD_WIDTH/DATA_WIDTH bytes,
//     first byte in the LSB, and pushes the word into a WORD_DEPTH-entry FIFO.
//     A downstream writer pops that FIFO with r_en.
// Ports:
//   clk        system clock; everything runs on its rising edge
//   rst        asynchronous active-high reset
//   rx         UART serial input; idles high
//   r_en       pop request for the word FIFO
//   rd_data    popped word, valid one cycle after an accepted r_en
//   rd_valid   one-cycle pulse marking rd_data
//   word_empty registered empty status of the word FIFO
//   word_full  registered full status of the word FIFO
//   overflow   sticky; a byte arrived while the byte FIFO was full
module uart_pack_fifo_top #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DEPTH      = 1024,
  parameter int WORD_WIDTH = 128,
  parameter int WORD_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  r_en,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  word_empty,
  output logic                  word_full,
  output logic                  overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BPW          = WORD_WIDTH / DATA_WIDTH;
  localparam int KW           = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW           = $clog2(DEPTH);
  localparam int WAW          = $clog2(WORD_DEPTH);

  // ---------------- rx synchronizer ----------------
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  byte_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rx_s) state <= START;
        end
        // Re-check the line at mid start bit; a short low pulse goes back to IDLE.
        START: begin
          if (baud_cnt == CW'(HALF_BIT - 1)) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // Right shift, so the first bit received (the LSB) ends up in bit 0.
        DATA: begin
          if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == BW'(DATA_WIDTH - 1)) state <= STOP;
            else                                bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // A low stop bit is a framing error; the byte is dropped silently.
        STOP: begin
          if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            byte_stb <= rx_s;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- byte FIFO ----------------
  logic [DATA_WIDTH-1:0] bmem [DEPTH];
  logic [AW:0]           bwr, brd;
  logic                  b_empty, b_full, b_wr, b_pop;
  logic [DATA_WIDTH-1:0] b_dout;

  logic [WORD_WIDTH-1:0] word;
  logic [KW-1:0]         k;
  logic                  word_rdy, w_push, w_pop;

  assign b_empty = (bwr == brd);
  assign b_full  = (bwr[AW] != brd[AW]) && (bwr[AW-1:0] == brd[AW-1:0]);
  assign b_wr    = byte_stb && !b_full;
  // The packer may take a new byte while it pushes a finished word out.
  assign b_pop   = !b_empty && (!word_rdy || w_push);
  assign b_dout  = bmem[brd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (b_wr) bmem[bwr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bwr      <= '0;
      brd      <= '0;
      overflow <= 1'b0;
    end else begin
      if (b_wr)  bwr <= bwr + 1'b1;
      if (b_pop) brd <= brd + 1'b1;
      if (byte_stb && b_full) overflow <= 1'b1;
    end
  end

  // ---------------- packer ----------------
  // A completed word waits in word_rdy until the word FIFO has room. Room
  // includes a slot that a pop frees in the same cycle. While it waits, no
  // bytes are taken, so the byte FIFO absorbs the backlog.
  assign w_pop  = r_en && !word_empty;
  assign w_push = word_rdy && (!word_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      k        <= '0;
      word_rdy <= 1'b0;
    end else begin
      if (w_push) word_rdy <= 1'b0;
      if (b_pop) begin
        for (int i = 0; i < BPW; i++)
          if (k == KW'(i)) word[i*DATA_WIDTH +: DATA_WIDTH] <= b_dout;
        if (k == KW'(BPW - 1)) begin
          k        <= '0;
          word_rdy <= 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  // ---------------- word FIFO ----------------
  logic [WORD_WIDTH-1:0] wmem [WORD_DEPTH];
  logic [WAW:0]          wwr, wrd, wwr_n, wrd_n;

  assign wwr_n = wwr + (WAW+1)'(w_push);
  assign wrd_n = wrd + (WAW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) wmem[wwr[WAW-1:0]] <= word;
  end

  // Status flags come from the next-state pointers, so they describe the FIFO after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wwr        <= '0;
      wrd        <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      word_empty <= 1'b1;
      word_full  <= 1'b0;
    end else begin
      wwr        <= wwr_n;
      wrd        <= wrd_n;
      rd_valid   <= w_pop;
      if (w_pop) rd_data <= wmem[wrd[WAW-1:0]];
      word_empty <= (wwr_n == wrd_n);
      word_full  <= (wwr_n[WAW] != wrd_n[WAW]) && (wwr_n[WAW-1:0] == wrd_n[WAW-1:0]);
    end
  end

endmodule

// File: tb/tb_uart_pack_fifo_top.sv
module tb_uart_pack_fifo_top;
  localparam int CPB   = 16;
  localparam int BAUD  = 115200;
  localparam int CLKF  = CPB * BAUD;
  localparam int DEPTH = 8;
  localparam int WD    = 8;
  localparam int WW    = 128;
  localparam int BPW   = 16;
  localparam int CAP   = WD * BPW + BPW + DEPTH;

  logic          clk = 1'b0, rst = 1'b1, rx = 1'b1, r_en = 1'b0;
  logic [WW-1:0] rd_data;
  logic          rd_valid, word_empty, word_full, overflow;

  // 20-unit period; a 100 ns pulse is 5 cycles, below the half-bit check point.
  always #10 clk = ~clk;

  uart_pack_fifo_top #(
    .DATA_WIDTH(8), .CLK_FREQ(CLKF), .BAUD_RATE(BAUD),
    .DEPTH(DEPTH), .WORD_WIDTH(WW), .WORD_DEPTH(WD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .r_en(r_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .word_empty(word_empty), .word_full(word_full), .overflow(overflow)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Model: the system holds the ordered stream of accepted bytes. Word n is
  // made of bytes 16n..16n+15. A byte is accepted only if the bytes still
  // inside (those not yet read out as words) fit in word FIFO + packer +
  // byte FIFO capacity.
  logic [7:0]    acc_q[$];
  int            popped;
  logic          m_ovf;
  logic          exp_valid;
  logic [WW-1:0] exp_data;

  function automatic int avail();
    int c;
    c = acc_q.size() / BPW - popped;
    return (c > WD) ? WD : c;
  endfunction

  function automatic logic [WW-1:0] word_of(input int n);
    logic [WW-1:0] w;
    for (int i = 0; i < BPW; i++) w[i*8 +: 8] = acc_q[n*BPW + i];
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_data  <= '0;
      popped    <= 0;
    end else if (r_en && avail() > 0) begin
      exp_valid <= 1'b1;
      exp_data  <= word_of(popped);
      popped    <= popped + 1;
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", {127'b0, rd_valid}, {127'b0, exp_valid});
    if (exp_valid) chk("rd_data", rd_data, exp_data);
  end

  // Stimulus helpers; all drive at negedge.
  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    if (acc_q.size() - BPW * popped < CAP) acc_q.push_back(b);
    else                                   m_ovf = 1'b1;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic pop_one();
    r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    settle();
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    acc_q.delete();
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_empty"}, {127'b0, word_empty}, {127'b0, avail() == 0});
    chk({tag, "_full"},  {127'b0, word_full},  {127'b0, avail() == WD});
    chk({tag, "_ovf"},   {127'b0, overflow},   {127'b0, m_ovf});
  endtask

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_data",  rd_data, '0);
    chk("rst_rd_valid", {127'b0, rd_valid},   '0);
    chk("rst_empty",    {127'b0, word_empty}, 128'd1);
    chk("rst_full",     {127'b0, word_full},  '0);
    chk("rst_ovf",      {127'b0, overflow},   '0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a frame, then a single byte.
    bit_time(1'b0); bit_time(1'b0); bit_time(1'b1);
    do_reset();
    send_byte(8'h55);
    settle();
    chk("t1_empty_lit", {127'b0, word_empty}, 128'd1);
    chk_status("t1");
    pop_one();
    do_reset();

    // Single word.
    for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
    settle();
    chk_status("t2");
    pop_one();
    chk("t2_word_lit", rd_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    chk("t2_empty_lit", {127'b0, word_empty}, 128'd1);

    // Six words, drained by holding r_en for 8 cycles.
    for (int i = 0; i < 96; i++) send_byte(8'(8'hA0 + i));
    settle();
    chk_status("t3");
    r_en = 1'b1;
    repeat (8) @(negedge clk);
    r_en = 1'b0;
    settle();
    chk("t3_last_lit", rd_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("t3_empty_lit", {127'b0, word_empty}, 128'd1);

    // Framing error, then a 100 ns glitch; neither may produce a byte.
    send_frame(8'h3C, 1'b0);
    bit_time(1'b1);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
    settle();
    chk_status("t4");
    pop_one();
    chk("t4_word_lit", rd_data, 128'h1F1E1D1C1B1A19181716151413121110);

    // Backpressure: fill the word FIFO, then one more word held in the packer.
    for (int i = 0; i < WD * BPW; i++) send_byte(8'(i * 3 + 1));
    settle();
    chk("t5_full_lit", {127'b0, word_full}, 128'd1);
    chk_status("t5a");
    for (int i = 0; i < BPW; i++) send_byte(8'(8'h80 + i));
    settle();
    chk_status("t5b");
    chk("t5_ovf_lit", {127'b0, overflow}, '0);

    // Overflow: DEPTH bytes still fit; the next one is dropped.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'hC0 + i));
    settle();
    chk("t6_ovf_before", {127'b0, overflow}, '0);
    send_byte(8'hEE);
    settle();
    chk("t6_ovf_lit", {127'b0, overflow}, 128'd1);
    chk_status("t6a");
    // Drain the words that are already complete. Then finish the partial word
    // whose first DEPTH bytes came from the byte FIFO.
    for (int i = 0; i < WD + 1; i++) pop_one();
    chk_status("t6b");
    for (int i = 0; i < BPW - DEPTH; i++) send_byte(8'(8'hD0 + i));
    settle();
    pop_one();
    chk("t6_word_lit", rd_data, 128'hD7D6D5D4D3D2D1D0C7C6C5C4C3C2C1C0);
    chk("t6_ovf_sticky", {127'b0, overflow}, 128'd1);
    do_reset();
    chk("t6_ovf_rst", {127'b0, overflow}, '0);
    chk("t6_empty_rst", {127'b0, word_empty}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
